prod_accum_stage: RTL
=====================

// Module: prod_accum_stage
// PURPOSE
//  Downstream consumer of the registered 32-bit unsigned product from the
//  16x16 approximate multiplier top. Sums N_TERMS consecutive products into
//  a wide saturating accumulator, then presents the block sum with a term
//  count on a valid/ready output.
//  Used for dot-product and error-statistics runs over the approximate multiplier.
// PARAMETERS
//  N_TERMS  16  products per block; legal range 1..65535
//  ACC_W    40  accumulator/output width; must be >= 32
//  CNT_W    16  width of term counter and out_count
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      p_in carries a product
//  in_ready   out  1      stage accepts p_in this cycle
//  p_in       in   32     unsigned product from multiplier top
//  flush      in   1      close current block early (1-cycle pulse)
//  out_valid  out  1      block result available
//  out_ready  in   1      consumer takes result
//  out_sum    out  ACC_W  saturated block sum
//  out_count  out  CNT_W  products summed in this block
//  out_ovf    out  1      saturation occurred in this block
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=ACCUM, acc=0, cnt=0, ovf=0,
//   out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
//  Reset mid-block or mid-DRAIN discards everything; no result is emitted.
//  States: ACCUM (in_ready=1, out_valid=0); DRAIN (in_ready=0, out_valid=1).
//  Accept: in_valid && in_ready at edge t.
//   At edge t: acc <= sat(acc + zext(p_in)); cnt <= cnt+1.
//   At edge t: ovf is set if the true sum exceeds 2^ACC_W-1.
//  sat(): clamp to 2^ACC_W-1. acc holds at max once saturated.
//   Later accepts still increment cnt.
//  ACCUM->DRAIN: on the edge of the N_TERMS-th accept, or any edge with flush=1.
//   At that edge out_sum/out_count/out_ovf load the post-update acc/cnt/ovf.
//   out_valid is 1 from the next cycle (1-cycle latency, last accept to result).
//  Flush in the same cycle as an accept: the product is included.
//   Only one result is emitted.
//  Flush with cnt=0: result out_sum=0, out_count=0, out_ovf=0 is still emitted.
//  Flush while in DRAIN: ignored.
//  DRAIN: out_sum/out_count/out_ovf held stable while out_valid && !out_ready.
//   p_in is ignored; upstream must hold its product.
//  DRAIN->ACCUM: on edge with out_ready=1. acc, cnt and ovf clear at that edge.
//   out_valid=0 and in_ready=1 from the next cycle.
//   Throughput: N_TERMS products per N_TERMS+1 cycles minimum.
//  out_sum, out_count and out_ovf keep their last value after handshake.
//  Only out_valid marks them as new.
//  No combinational path from any input to any output; all outputs are registered.
// TESTING
//  1. Reset, N_TERMS=4, p_in=1,2,3,4 back-to-back.
//     -> out_valid at cycle after 4th accept; out_sum=10, out_count=4, out_ovf=0.
//  2. Hold out_ready=0 for 5 cycles in DRAIN with in_valid=1.
//     -> in_ready=0 and outputs stable; after out_ready, the next block starts from acc=0.
//  3. ACC_W=33, p_in=32'hFFFF_FFFF x4.
//     -> out_sum=33'h1_FFFF_FFFF saturated, out_ovf=1, out_count=4.
//     -> next block out_ovf=0.
//  4. 2 accepts (5, 7), then flush, including the case of flush with a 3rd accept of 9.
//     -> out_count=2, out_sum=12 / out_count=3, out_sum=21.
//  5. Flush with no accepts.
//     -> out_valid, out_sum=0, out_count=0. A second flush during DRAIN gives no extra result.
//  6. rst after 2 of 4 accepts, then p_in=1 x4.
//     -> no partial result; out_sum=4, out_count=4.
//     Random in_valid/out_ready gaps: sum matches the reference model.

Source files
------------

// File: rtl/prod_accum_stage.sv
// Block accumulator for the approximate multiplier product stream: sums
// N_TERMS products (or fewer on flush) into a saturating sum and hands it off on valid/ready.
module prod_accum_stage #(
   parameter int unsigned N_TERMS = 16,
   parameter int unsigned ACC_W   = 40,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      p_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt;
   logic [ACC_W:0]   sum_wide;
   logic             close_block;

   // Handshake flags decode straight from the state flop, so no input reaches an output.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DRAIN);

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      ovf_nxt     = ovf;
      close_block = 1'b0;
      sum_wide    = {1'b0, acc} + (ACC_W + 1)'(p_in);

      unique case (state)
         ACCUM: begin
            if (in_valid) begin
               if (sum_wide[ACC_W]) begin
                  acc_nxt = '1;
                  ovf_nxt = 1'b1;
               end else begin
                  acc_nxt = sum_wide[ACC_W-1:0];
               end
               cnt_nxt = cnt + CNT_W'(1);
            end
            // A flush on the same edge as an accept still closes just one block.
            if ((in_valid && (cnt_nxt == LAST_CNT)) || flush) begin
               close_block = 1'b1;
               state_nxt   = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               state_nxt = ACCUM;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
         // Result registers load the post-update totals and then hold until the next close.
         if (close_block) begin
            out_sum   <= acc_nxt;
            out_count <= cnt_nxt;
            out_ovf   <= ovf_nxt;
         end
      end
   end

endmodule
